cfdf_firing_scheduler: RTL and testbench

- Top-level CFDF enable/invoke scheduler for the polynomial evaluation actor.
- Decides when the firing-state FSM may fire, based on input FIFO populations, output FIFO free space and the current decoded instruction.
- Alternates the SETUP_INSTR and INSTR modes, issues one start pulse per firing, and waits for that FSM's done.
- Watchdog recovers from a firing that never completes.

---
 rtl/cfdf_firing_scheduler.sv | 161 ++++++++++++++++
 tb/tb_cfdf_firing_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfdf_firing_scheduler.sv
// CFDF enable/invoke scheduler for the polynomial evaluation actor: checks FIFO readiness
// for the current mode/instruction, launches one firing of the firing FSM and waits for done.
module cfdf_firing_scheduler #(
    parameter int word_size      = 16,
    parameter int timeout_cycles = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_sched,
    input  logic [word_size-1:0] pop_in_fifo_command,
    input  logic [word_size-1:0] pop_in_fifo_data,
    input  logic [word_size-1:0] free_out_fifo,
    input  logic [7:0]           instr,
    input  logic [4:0]           arg2,
    input  logic                 done_fsm2,
    output logic                 start_fsm2,
    output logic [1:0]           next_instr,
    output logic                 busy,
    output logic                 err_instr,
    output logic                 timeout,
    output logic [15:0]          fire_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_FIRE,
        S_WAIT,
        S_ADVANCE
    } state_t;

    typedef enum logic [1:0] {
        MODE_SETUP = 2'b00,
        MODE_INSTR = 2'b01
    } mode_t;

    localparam logic [7:0] INSTR_STP = 8'd0;
    localparam logic [7:0] INSTR_EVP = 8'd1;
    localparam logic [7:0] INSTR_EVB = 8'd2;
    localparam logic [7:0] INSTR_RST = 8'd3;

    localparam int              WD_W    = (timeout_cycles > 2) ? $clog2(timeout_cycles) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(timeout_cycles - 1);

    state_t                 state_q, state_d;
    mode_t                  mode_q, mode_d;
    mode_t                  next_instr_q, next_instr_d;
    logic [WD_W-1:0]        wd_q, wd_d;
    logic [15:0]            fire_count_q, fire_count_d;
    logic                   start_q, start_d;
    logic                   busy_q, busy_d;

    logic [word_size-1:0]   stp_need;
    logic [word_size-1:0]   evb_need;
    logic                   enable_ok;
    logic                   bad_instr;
    logic                   wd_expired;

    // STP needs N+1 data words; the +1 is done at 6 bits so N=31 still asks for 32.
    assign stp_need  = word_size'({1'b0, arg2} + 6'd1);
    assign evb_need  = word_size'(arg2);
    assign bad_instr = (mode_q == MODE_INSTR) && (instr > INSTR_RST);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        enable_ok = 1'b0;
        if (mode_q == MODE_SETUP) begin
            enable_ok = (pop_in_fifo_command != '0);
        end else begin
            case (instr)
                INSTR_STP: enable_ok = (pop_in_fifo_data >= stp_need) && (free_out_fifo != '0);
                INSTR_EVP: enable_ok = (pop_in_fifo_data != '0) && (free_out_fifo != '0);
                INSTR_EVB: enable_ok = (arg2 == 5'd0) ? (free_out_fifo != '0)
                                     : ((pop_in_fifo_data >= evb_need) && (free_out_fifo >= evb_need));
                INSTR_RST: enable_ok = 1'b1;
                default:   enable_ok = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        next_instr_d = next_instr_q;
        wd_d         = wd_q;
        fire_count_d = fire_count_q;
        case (state_q)
            S_IDLE: begin
                if (en_sched) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (bad_instr) begin
                    state_d = S_ADVANCE;
                    mode_d  = MODE_SETUP;
                end else if (enable_ok) begin
                    state_d      = S_FIRE;
                    next_instr_d = mode_q;
                end else if (!en_sched) begin
                    state_d = S_IDLE;
                end
            end
            S_FIRE: begin
                state_d = S_WAIT;
                wd_d    = '0;
            end
            S_WAIT: begin
                // A completed INSTR firing (RST included) always lands back in SETUP_INSTR.
                if (done_fsm2) begin
                    state_d      = S_ADVANCE;
                    mode_d       = (mode_q == MODE_SETUP) ? MODE_INSTR : MODE_SETUP;
                    fire_count_d = fire_count_q + 16'd1;
                end else if (wd_q == WD_LAST) begin
                    state_d = S_ADVANCE;
                    mode_d  = MODE_SETUP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_ADVANCE: begin
                state_d = en_sched ? S_CHECK : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        start_d = (state_d == S_FIRE);
        busy_d  = (state_d == S_FIRE) || (state_d == S_WAIT);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            mode_q       <= MODE_SETUP;
            next_instr_q <= MODE_SETUP;
            wd_q         <= '0;
            fire_count_q <= 16'd0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            next_instr_q <= next_instr_d;
            wd_q         <= wd_d;
            fire_count_q <= fire_count_d;
            start_q      <= start_d;
            busy_q       <= busy_d;
        end
    end

    assign wd_expired = (wd_q == WD_LAST);

    // Error and abort pulses belong to the decision cycle itself, so they decode state plus inputs.
    assign err_instr  = (state_q == S_CHECK) && bad_instr;
    assign timeout    = (state_q == S_WAIT) && wd_expired && !done_fsm2;
    assign start_fsm2 = start_q;
    assign busy       = busy_q;
    assign next_instr = next_instr_q;
    assign fire_count = fire_count_q;

endmodule

// File: tb/tb_cfdf_firing_scheduler.sv
// Self-checking bench for cfdf_firing_scheduler: a firing-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_cfdf_firing_scheduler;

    localparam int WS = 16;
    localparam int TC = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          en_sched;
    logic [WS-1:0] pop_cmd;
    logic [WS-1:0] pop_data;
    logic [WS-1:0] free_out;
    logic [7:0]    instr;
    logic [4:0]    arg2;
    logic          done_fsm2;
    logic          start_fsm2;
    logic [1:0]    next_instr;
    logic          busy;
    logic          err_instr;
    logic          timeout;
    logic [15:0]   fire_count;

    int checks = 0;
    int errors = 0;

    cfdf_firing_scheduler #(.word_size(WS), .timeout_cycles(TC)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .en_sched            (en_sched),
        .pop_in_fifo_command (pop_cmd),
        .pop_in_fifo_data    (pop_data),
        .free_out_fifo       (free_out),
        .instr               (instr),
        .arg2                (arg2),
        .done_fsm2           (done_fsm2),
        .start_fsm2          (start_fsm2),
        .next_instr          (next_instr),
        .busy                (busy),
        .err_instr           (err_instr),
        .timeout             (timeout),
        .fire_count          (fire_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the scheduler is either idle, evaluating readiness, issuing the start,
    // waiting (age = cycles since the start cycle) or settling for one cycle after a firing.
    bit          m_eval      = 0;
    bit          m_start     = 0;
    bit          m_settle    = 0;
    int          m_age       = 0;
    bit          m_mode      = 0;   // 0 = SETUP_INSTR, 1 = INSTR
    bit          m_fire_mode = 0;
    bit          m_fired_rst = 0;
    int unsigned m_count     = 0;
    bit          e_err, e_to, e_busy;

    function automatic bit may_fire();
        int d, f, a;
        d = int'(pop_data);
        f = int'(free_out);
        a = int'(arg2);
        if (!m_mode) return pop_cmd >= 1;
        case (instr)
            8'd0:    return (d >= a + 1) && (f >= 1);
            8'd1:    return (d >= 1) && (f >= 1);
            8'd2:    return (a == 0) ? (f >= 1) : ((d >= a) && (f >= a));
            8'd3:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            m_eval = 0; m_start = 0; m_settle = 0; m_age = 0; m_mode = 0; m_count = 0;
            check("rst_start", start_fsm2, 0);
            check("rst_busy", busy, 0);
            check("rst_err", err_instr, 0);
            check("rst_timeout", timeout, 0);
            check("rst_count", fire_count, 0);
        end else begin
            e_err  = m_eval && m_mode && (instr > 8'd3);
            e_to   = (m_age == TC) && !done_fsm2;
            e_busy = m_start || (m_age > 0);
            check("m_start", start_fsm2, m_start);
            check("m_busy", busy, e_busy);
            check("m_err", err_instr, e_err);
            check("m_timeout", timeout, e_to);
            check("m_count", fire_count, m_count & 32'hFFFF);
            if (e_busy) check("m_next_instr", next_instr, {1'b0, m_fire_mode});
            if (m_start) begin
                m_start = 0;
                m_age   = 1;
            end else if (m_age > 0) begin
                if (done_fsm2) begin
                    m_count = (m_count + 1) % 65536;
                    m_mode  = !m_fire_mode;
                    if (m_fired_rst) m_mode = 0;
                    m_age    = 0;
                    m_settle = 1;
                end else if (m_age == TC) begin
                    m_mode   = 0;
                    m_age    = 0;
                    m_settle = 1;
                end else begin
                    m_age++;
                end
            end else if (m_settle) begin
                m_settle = 0;
                m_eval   = en_sched;
            end else if (m_eval) begin
                if (m_mode && instr > 8'd3) begin
                    m_eval = 0; m_settle = 1; m_mode = 0;
                end else if (may_fire()) begin
                    m_eval      = 0;
                    m_start     = 1;
                    m_fire_mode = m_mode;
                    m_fired_rst = m_mode && (instr == 8'd3);
                end else if (!en_sched) begin
                    m_eval = 0;
                end
            end else begin
                m_eval = en_sched;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_done();
        done_fsm2 = 1'b1;
        tick();
        done_fsm2 = 1'b0;
    endtask

    task automatic wait_start();
        bit seen;
        seen = 0;
        for (int i = 0; i < 64 && !seen; i++) begin
            tick();
            seen = start_fsm2;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_start: start_fsm2 stayed 0 for 64 cycles, expected a pulse");
        end
    endtask

    initial begin
        rst = 0; en_sched = 0; pop_cmd = 0; pop_data = 0; free_out = 0;
        instr = 0; arg2 = 0; done_fsm2 = 0;
        repeat (3) tick();
        rst = 1;
        tick();

        // 1: SETUP firing gated on command FIFO population
        en_sched = 1;
        repeat (4) tick();
        check("t1_blocked", start_fsm2, 0);
        pop_cmd = 1;
        tick();
        check("t1_start", start_fsm2, 1);
        check("t1_mode", next_instr, 2'b00);
        pop_cmd = 0; instr = 8'd0; arg2 = 5'd3; pop_data = 3; free_out = 4;
        tick();
        pulse_done();
        check("t1_count", fire_count, 1);

        // 2: STP needs arg2+1 data words; then next SETUP firing at done+3
        repeat (3) tick();
        check("t2_stp_blocked", start_fsm2, 0);
        pop_data = 4;
        tick();
        check("t2_stp_start", start_fsm2, 1);
        check("t2_stp_mode", next_instr, 2'b01);
        pop_cmd = 1;
        tick();
        pulse_done();
        tick();
        check("t2_not_yet", start_fsm2, 0);
        tick();
        check("t2_latency", start_fsm2, 1);
        check("t2_back_setup", next_instr, 2'b00);

        // 3: EVB gated on both data and free space; arg2=0 needs only one free slot
        pop_cmd = 0; instr = 8'd2; arg2 = 5'd5; pop_data = 5; free_out = 4;
        tick();
        pulse_done();
        repeat (3) tick();
        check("t3_evb_blocked", start_fsm2, 0);
        free_out = 5;
        tick();
        check("t3_evb_start", start_fsm2, 1);
        pop_cmd = 1;
        tick();
        pulse_done();
        wait_start();
        arg2 = 5'd0; free_out = 1; pop_data = 0; pop_cmd = 0;
        tick();
        pulse_done();
        wait_start();
        check("t3_evb0_mode", next_instr, 2'b01);
        tick();
        pulse_done();
        check("t3_count", fire_count, 6);

        // 4: undefined instruction
        pop_cmd = 1;
        wait_start();
        pop_cmd = 0; instr = 8'd7;
        tick();
        pulse_done();
        check("t4_err_adv", err_instr, 0);
        tick();
        check("t4_err_pulse", err_instr, 1);
        check("t4_no_start", start_fsm2, 0);
        tick();
        check("t4_err_end", err_instr, 0);
        check("t4_count_same", fire_count, 7);
        tick();
        instr = 8'd1; pop_cmd = 1;
        tick();
        check("t4_forced_setup_start", start_fsm2, 1);
        check("t4_forced_setup", next_instr, 2'b00);

        // 5: watchdog abort 16 cycles after FIRE, and done winning the same cycle
        pop_cmd = 0; pop_data = 1; free_out = 1;
        tick();
        pulse_done();
        wait_start();
        repeat (15) tick();
        check("t5_before", timeout, 0);
        tick();
        check("t5_timeout", timeout, 1);
        tick();
        check("t5_after", timeout, 0);
        check("t5_count_same", fire_count, 8);
        pop_cmd = 1;
        wait_start();
        check("t5_setup_after_to", next_instr, 2'b00);
        pop_cmd = 0;
        tick();
        pulse_done();
        wait_start();
        repeat (16) tick();
        done_fsm2 = 1;
        #1;
        check("t5_done_wins", timeout, 0);
        tick();
        done_fsm2 = 0;
        check("t5_done_count", fire_count, 10);

        // RST firing always returns to SETUP_INSTR
        pop_cmd = 1; instr = 8'd3;
        wait_start();
        pop_cmd = 0;
        tick();
        pulse_done();
        wait_start();
        check("rst_fire_mode", next_instr, 2'b01);
        pop_data = 0; free_out = 0;
        tick();
        pulse_done();
        repeat (4) tick();
        check("rst_then_setup", start_fsm2, 0);
        check("rst_count12", fire_count, 12);

        // en_sched=0 holds the scheduler idle
        en_sched = 0;
        repeat (3) tick();
        pop_cmd = 1;
        repeat (4) tick();
        check("en_off_start", start_fsm2, 0);
        check("en_off_busy", busy, 0);
        en_sched = 1;
        wait_start();
        check("en_on_mode", next_instr, 2'b00);

        // 6: asynchronous reset mid-firing
        tick();
        tick();
        rst = 0;
        #1;
        check("t6_start", start_fsm2, 0);
        check("t6_busy", busy, 0);
        check("t6_count", fire_count, 0);
        check("t6_next_instr", next_instr, 2'b00);
        check("t6_timeout", timeout, 0);
        repeat (2) tick();
        rst = 1;
        wait_start();
        check("t6_setup_after_rst", next_instr, 2'b00);
        check("t6_count_after", fire_count, 0);
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit reached");
    end

endmodule
